spi_master_xfer: RTL

Mode-0 (CPOL=0, CPHA=0), MSB-first SPI master shift engine. It sits directly downstream of the CPU-side SPI register file.
- The register file hands it one word per transfer over a valid/ready handshake.
- The block serialises the word on mosi while capturing miso, then returns the received word with a one-cycle valid pulse.
- It owns sclk generation, chip-select framing and bit counting; it does no buffering beyond one in-flight word.

---
 rtl/spi_master_xfer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/spi_master_xfer.sv
// Mode-0 MSB-first SPI master: one word in over valid/ready, one word out
// with a single-cycle valid pulse. All outputs come straight from flops.
module spi_master_xfer #(
    parameter int W_DATA  = 32,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_DATA-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [W_DATA-1:0] rx_data,
    output logic              rx_valid,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (W_DATA > 1) ? $clog2(W_DATA) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(W_DATA - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        TRAIL
    } state_t;

    state_t            state, state_nxt;
    logic [DW-1:0]     div_cnt, div_cnt_nxt;
    logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
    logic [W_DATA-1:0] tx_sh, tx_sh_nxt;
    logic [W_DATA-1:0] rx_sh, rx_sh_nxt;
    logic [W_DATA-1:0] rx_data_nxt;
    logic              tx_ready_nxt;
    logic              rx_valid_nxt;
    logic              sclk_nxt;
    logic              mosi_nxt;
    logic              cs_n_nxt;

    logic              div_end;
    logic              last_bit;
    logic [W_DATA-1:0] tx_shl;
    logic [W_DATA-1:0] rx_in;

    always_comb begin
        div_end = (div_cnt == DIV_LAST);
        last_bit = (bit_cnt == BIT_LAST);
        tx_shl = tx_sh << 1;
        rx_in = rx_sh << 1;
        rx_in[0] = miso;

        state_nxt    = state;
        div_cnt_nxt  = div_end ? '0 : div_cnt + DW'(1);
        bit_cnt_nxt  = bit_cnt;
        tx_sh_nxt    = tx_sh;
        rx_sh_nxt    = rx_sh;
        rx_data_nxt  = rx_data;
        tx_ready_nxt = tx_ready;
        rx_valid_nxt = 1'b0;
        sclk_nxt     = sclk;
        mosi_nxt     = mosi;
        cs_n_nxt     = cs_n;

        unique case (state)
            IDLE: begin
                div_cnt_nxt = '0;
                if (tx_valid) begin
                    state_nxt    = LEAD;
                    bit_cnt_nxt  = '0;
                    tx_sh_nxt    = tx_data;
                    rx_sh_nxt    = '0;
                    mosi_nxt     = tx_data[W_DATA-1];
                    cs_n_nxt     = 1'b0;
                    tx_ready_nxt = 1'b0;
                end
            end
            LEAD: begin
                if (div_end) begin
                    state_nxt = HIGH;
                    sclk_nxt  = 1'b1;
                    rx_sh_nxt = rx_in;
                end
            end
            HIGH: begin
                // falling sclk edge: present the next bit, or 0 after the last
                if (div_end) begin
                    state_nxt = LOW;
                    sclk_nxt  = 1'b0;
                    tx_sh_nxt = tx_shl;
                    mosi_nxt  = last_bit ? 1'b0 : tx_shl[W_DATA-1];
                end
            end
            LOW: begin
                if (div_end) begin
                    if (!last_bit) begin
                        state_nxt   = HIGH;
                        bit_cnt_nxt = bit_cnt + BW'(1);
                        sclk_nxt    = 1'b1;
                        rx_sh_nxt   = rx_in;
                    end else begin
                        state_nxt = TRAIL;
                    end
                end
            end
            TRAIL: begin
                if (div_end) begin
                    state_nxt    = IDLE;
                    cs_n_nxt     = 1'b1;
                    tx_ready_nxt = 1'b1;
                    rx_valid_nxt = 1'b1;
                    rx_data_nxt  = rx_sh;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_data  <= '0;
            tx_ready <= 1'b1;
            rx_valid <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
        end else begin
            state    <= state_nxt;
            div_cnt  <= div_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            tx_sh    <= tx_sh_nxt;
            rx_sh    <= rx_sh_nxt;
            rx_data  <= rx_data_nxt;
            tx_ready <= tx_ready_nxt;
            rx_valid <= rx_valid_nxt;
            sclk     <= sclk_nxt;
            mosi     <= mosi_nxt;
            cs_n     <= cs_n_nxt;
        end
    end

endmodule
